// File: rtl/seq_mult_pkg.sv
// Shared types and constants for the shift-and-add sequential multiplier.
package seq_mult_pkg;

  localparam int DEFAULT_N = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_mult.sv
// Unsigned N x N shift-and-add multiplier: fixed N-cycle RUN phase, one-cycle done pulse
// that doubles as the write enable of a downstream N-bit register.
module seq_mult
  import seq_mult_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic         clk,
  input  logic         CLR,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         busy,
  output logic         done,
  output logic         regWE,
  output logic [N-1:0] DataOut,
  output logic         Ovf
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t         state;
  logic [N-1:0]   mcand;
  logic [N-1:0]   mplier;
  logic [2*N-1:0] acc;
  logic [2*N-1:0] acc_next;
  logic [CW-1:0]  cnt;

  // Partial product for the current bit; the 2N-bit sum cannot overflow.
  always_comb begin
    acc_next = acc;
    if (mplier[0]) begin
      acc_next = acc + ({{N{1'b0}}, mcand} << cnt);
    end
  end

  always_ff @(posedge clk or posedge CLR) begin
    if (CLR) begin
      state   <= IDLE;
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      DataOut <= '0;
      Ovf     <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            mcand  <= A;
            mplier <= B;
            acc    <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          acc    <= acc_next;
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
          if (cnt == LAST) begin
            state   <= DONE;
            done    <= 1'b1;
            DataOut <= acc_next[N-1:0];
            Ovf     <= |acc_next[2*N-1:N];
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign regWE = done;

endmodule
